// File: rtl/onehot_arb_pkg.sv
// Shared constants, FSM state type and rotated-priority mask for the one-hot request arbiter.
// Latency: n/a (package). Backpressure: n/a.
// Used by onehot_req_arb and rr_pick.
package onehot_arb_pkg;

    localparam int ARB_N    = 8;
    localparam int ARB_IDXW = 3;

    typedef enum logic {
        ARB_EMPTY = 1'b0,
        ARB_FULL  = 1'b1
    } arb_state_t;

    // Bits at or above ptr are the high-priority half of the round-robin scan.
    function automatic logic [ARB_N-1:0] rr_mask(input logic [ARB_IDXW-1:0] ptr);
        logic [ARB_N-1:0] m;
        for (int k = 0; k < ARB_N; k++) begin
            m[k] = (k >= int'(ptr));
        end
        return m;
    endfunction

endpackage

// File: rtl/onehot_req_arb_rr_pick.sv
// Round-robin picker: first set pend bit scanning from ptr upwards with wrap.
// Latency: combinational. Backpressure: none (pure function of pend/ptr).
// Double-width scan: masked copy in the low half, full copy in the high half.
module rr_pick
    import onehot_arb_pkg::*;
#(
    parameter int N    = ARB_N,
    parameter int IDXW = ARB_IDXW
) (
    input  logic [N-1:0]    pend,
    input  logic [IDXW-1:0] ptr,
    output logic [IDXW-1:0] idx,
    output logic            any
);

    logic [2*N-1:0] dbl;

    assign dbl = {pend, pend & rr_mask(ptr)};
    assign any = |pend;

    // Scan high to low so the lowest set bit of the doubled word wins.
    always_comb begin
        idx = '0;
        for (int j = 2*N-1; j >= 0; j--) begin
            if (dbl[j]) begin
                idx = IDXW'(j % N);
            end
        end
    end

endmodule

// File: rtl/onehot_req_arb.sv
// Pending-register round-robin arbiter issuing a registered one-hot grant (EDGE_DETECT_EN: capture on req rising edge).
// Latency: req sampled at edge t -> grant valid after edge t+1; 1 grant/cycle sustained.
// Backpressure: gnt_rdy_i=0 holds the grant stable; requests keep accumulating in pend.
module onehot_req_arb
    import onehot_arb_pkg::*;
#(
    parameter int N    = ARB_N,
    parameter int IDXW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en_i,
    input  logic [N-1:0]    req_i,
    output logic [N-1:0]    gnt_o,
    output logic [IDXW-1:0] gnt_idx_o,
    output logic            gnt_vld_o,
    input  logic            gnt_rdy_i,
    output logic [N-1:0]    pend_o
);

    arb_state_t      state, state_nxt;
    logic [N-1:0]    pend, pend_nxt;
    logic [N-1:0]    cap;
    logic [N-1:0]    clr;
    logic [N-1:0]    gnt_nxt;
    logic [IDXW-1:0] idx_nxt;
    logic [IDXW-1:0] ptr, ptr_nxt;
    logic [IDXW-1:0] pick_idx;
    logic            pick_any;
    logic            load;

`ifdef EDGE_DETECT_EN
    logic [N-1:0] req_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q <= '0;
        end else begin
            req_q <= req_i;
        end
    end

    assign cap = req_i & ~req_q;
`else
    assign cap = req_i;
`endif

    rr_pick #(
        .N    (N),
        .IDXW (IDXW)
    ) u_pick (
        .pend (pend),
        .ptr  (ptr),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    assign load = ((state == ARB_EMPTY) || gnt_rdy_i) && en_i && pick_any;

    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt_o;
        idx_nxt   = gnt_idx_o;
        ptr_nxt   = ptr;
        clr       = '0;
        if (load) begin
            state_nxt = ARB_FULL;
            gnt_nxt   = N'(1) << pick_idx;
            idx_nxt   = pick_idx;
            clr       = N'(1) << pick_idx;
            ptr_nxt   = (pick_idx == IDXW'(N-1)) ? '0 : pick_idx + 1'b1;
        end else if ((state == ARB_FULL) && gnt_rdy_i) begin
            state_nxt = ARB_EMPTY;
            gnt_nxt   = '0;
            idx_nxt   = '0;
        end
    end

    // A fresh capture on the line being granted wins over its clear.
    assign pend_nxt = (pend & ~clr) | cap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ARB_EMPTY;
            pend      <= '0;
            ptr       <= '0;
            gnt_o     <= '0;
            gnt_idx_o <= '0;
        end else begin
            state     <= state_nxt;
            pend      <= pend_nxt;
            ptr       <= ptr_nxt;
            gnt_o     <= gnt_nxt;
            gnt_idx_o <= idx_nxt;
        end
    end

    assign gnt_vld_o = (state == ARB_FULL);
    assign pend_o    = pend;

endmodule

// File: tb/tb_onehot_req_arb.sv
// Directed bench for onehot_req_arb: expected grant indices queued by stimulus, checked by a monitor on each transfer.
module tb_onehot_req_arb;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en_i;
    logic [7:0] req_i;
    logic [7:0] gnt_o;
    logic [2:0] gnt_idx_o;
    logic       gnt_vld_o;
    logic       gnt_rdy_i;
    logic [7:0] pend_o;

    int total = 0;
    int bad   = 0;
    int exp_q[$];

    onehot_req_arb dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en_i      (en_i),
        .req_i     (req_i),
        .gnt_o     (gnt_o),
        .gnt_idx_o (gnt_idx_o),
        .gnt_vld_o (gnt_vld_o),
        .gnt_rdy_i (gnt_rdy_i),
        .pend_o    (pend_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (gnt_vld_o && n < 40) begin
            tick();
            n++;
        end
        chk({name, "_drain_timeout"}, 32'(n >= 40), 32'd0);
    endtask

    // Monitor: every transfer (vld & rdy) must match the head of the queue.
    always @(negedge clk) begin
        if (rst_n) begin
            if (!gnt_vld_o) begin
                chk("idle_zero", {24'd0, gnt_o}, 32'd0);
            end else if (gnt_rdy_i) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_grant actual=%0h required=none", gnt_o);
                end else begin
                    int e;
                    e = exp_q.pop_front();
                    chk("grant_word", {24'd0, gnt_o}, 32'(1) << e);
                    chk("grant_idx", {29'd0, gnt_idx_o}, 32'(e));
                end
            end
        end
    end

    initial begin
        rst_n     = 1'b1;
        en_i      = 1'b1;
        req_i     = 8'hFF;
        gnt_rdy_i = 1'b1;
        #2 rst_n  = 1'b0;

        // 1: reset with all requests high
        tick(); tick();
        chk("rst_gnt", {24'd0, gnt_o}, 32'd0);
        chk("rst_idx", {29'd0, gnt_idx_o}, 32'd0);
        chk("rst_vld", {31'd0, gnt_vld_o}, 32'd0);
        chk("rst_pend", {24'd0, pend_o}, 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) exp_q.push_back(i);
        tick();
        req_i = 8'h00;
        chk("t1_edge1_vld", {31'd0, gnt_vld_o}, 32'd0);
        chk("t1_edge1_pend", {24'd0, pend_o}, 32'hFF);
        tick();
        chk("t1_edge2_gnt", {24'd0, gnt_o}, 32'h01);
        drain("t1");
        chk("t1_pend_empty", {24'd0, pend_o}, 32'd0);

        // 2: single-cycle pulse of three lines
        req_i = 8'b1010_0100;
        exp_q.push_back(2); exp_q.push_back(5); exp_q.push_back(7);
        tick();
        req_i = 8'h00;
        tick();
        drain("t2");
        chk("t2_pend_empty", {24'd0, pend_o}, 32'd0);
        chk("t2_vld_low", {31'd0, gnt_vld_o}, 32'd0);

        // 3: backpressure holds grant 3 while line 1 accumulates
        req_i = 8'h08;
        exp_q.push_back(3);
        tick();
        req_i = 8'h00;
        gnt_rdy_i = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            if (i == 0) req_i = 8'h02;
            tick();
            req_i = 8'h00;
            chk("t3_hold_gnt", {24'd0, gnt_o}, 32'h08);
            chk("t3_hold_idx", {29'd0, gnt_idx_o}, 32'd3);
            chk("t3_hold_vld", {31'd0, gnt_vld_o}, 32'd1);
        end
        chk("t3_pend", {24'd0, pend_o}, 32'h02);
        exp_q.push_back(1);
        gnt_rdy_i = 1'b1;
        tick();
        drain("t3");

        // 4: move ptr to 7, then pend 0x81 wraps 7 -> 0
        req_i = 8'h40;
        exp_q.push_back(6);
        tick();
        req_i = 8'h00;
        tick();
        drain("t4a");
        req_i = 8'h81;
        exp_q.push_back(7); exp_q.push_back(0);
        tick();
        req_i = 8'h00;
        chk("t4_pend", {24'd0, pend_o}, 32'h81);
        tick();
        drain("t4b");

        // 5: enable gating and held request
        en_i  = 1'b0;
        req_i = 8'h10;
        tick(); tick();
        chk("t5_pend_gated", {24'd0, pend_o}, 32'h10);
        chk("t5_vld_gated", {31'd0, gnt_vld_o}, 32'd0);
`ifdef EDGE_DETECT_EN
        exp_q.push_back(4);
`else
        for (int i = 0; i < 4; i++) exp_q.push_back(4);
`endif
        en_i = 1'b1;
        tick();
        chk("t5_gnt", {24'd0, gnt_o}, 32'h10);
        tick(); tick();
        req_i = 8'h00;
        drain("t5");

        // 6: async reset while a grant is held
        gnt_rdy_i = 1'b0;
        req_i = 8'h0F;
        tick();
        req_i = 8'h00;
        tick();
        chk("t6_vld_before", {31'd0, gnt_vld_o}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_async_vld", {31'd0, gnt_vld_o}, 32'd0);
        chk("t6_async_gnt", {24'd0, gnt_o}, 32'd0);
        chk("t6_async_pend", {24'd0, pend_o}, 32'd0);
        tick();
        rst_n = 1'b1;
        gnt_rdy_i = 1'b1;
        tick();
        chk("t6_idle_after", {31'd0, gnt_vld_o}, 32'd0);
        req_i = 8'h88;
        exp_q.push_back(3); exp_q.push_back(7);
        tick();
        req_i = 8'h00;
        tick();
        drain("t6");

        tick();
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
